mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle MIPS controller: a decode table plus a FETCH/DECODE/EXEC/MEM/WB state machine.
//  Sits beside the shared datapath (PC, IR, GRF, ALU, DM) and drives its write enables and mux selects once per state.
//  Adds bne, jalr, mult/div with a programmable busy wait, and a memory-ready handshake.
//  Mux-select encodings match the existing pipelined decoder.
// PARAMETERS
//  MULT_CYCLES  5   EXEC->done latency of mult/multu, in cycles, >=1
//  DIV_CYCLES   10  EXEC->done latency of div/divu, in cycles, >=1
//  CNT_W        4   width of the busy counter; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous reset, active-low (0 = reset)
//  instr      in   32  IR contents (valid from DECODE onward)
//  zero       in   1   ALU equality flag (rs==rt) in EXEC
//  mem_ready  in   1   DM access complete, sampled in MEM
//  pc_we      out  1   PC write enable
//  ir_we      out  1   IR write enable
//  reg_write  out  1   GRF write enable
//  mem_write  out  1   DM write enable
//  RegDst     out  3   000 rd, 001 rt, 010 $31
//  NPCop      out  3   000 PC+4, 001 branch, 010 jal, 011 jr/jalr, 100 j
//  MemToReg   out  3   000 ALU, 001 DM, 010 PC+4, 011 HI, 100 LO
//  ALUSrc     out  3   000 rt, 001 ext imm
//  Extop      out  2   00 zero, 01 sign, 10 lui
//  ALUop      out  3   000 add, 001 sub, 010 or, 011 and, 100 slt
//  md_start   out  1   one-cycle pulse: HI/LO unit latch operands
//  md_busy    out  1   high while in MDWAIT
//  instr_done out  1   one-cycle pulse on the last cycle of every instruction
//  state      out  3   current FSM state (debug)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state<=FETCH, busy counter<=0; trap<=0 when trap exists.
//    While reset==0, all enables/pulses are forced 0 regardless of state.
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, TRAP=6.
//  - FETCH: ir_we=1, pc_we=1 with NPCop=000; next state DECODE.
//  - DECODE:
//    - j: pc_we=1, NPCop=100.
//    - jal: pc_we=1, reg_write=1, RegDst=010, MemToReg=010.
//    - jr: pc_we=1, NPCop=011.
//    - jalr: as jr, plus reg_write=1 to rd with MemToReg=010.
//    - j/jal/jr/jalr: instr_done=1, next state FETCH. All other instructions go to EXEC.
//  - EXEC:
//    - R-type ALU ops, ori, lui, mfhi, mflo: next state WB.
//    - lw/sw: next state MEM.
//    - beq: pc_we=zero; bne: pc_we=~zero; both NPCop=001, instr_done=1, next state FETCH.
//    - mult/multu: md_start=1, counter<=MULT_CYCLES-1, next state MDWAIT.
//    - div/divu: md_start=1, counter<=DIV_CYCLES-1, next state MDWAIT.
//    - Unrecognised opcode/funct: see CONFIGURATION.
//  - MEM: hold while mem_ready==0 with all enables 0.
//    - When mem_ready==1: sw asserts mem_write=1 for exactly that cycle, instr_done=1, next FETCH; lw goes to WB.
//  - WB: reg_write=1, instr_done=1, next state FETCH.
//  - MDWAIT: md_busy=1. If counter==0: instr_done=1, next FETCH; else counter decrements.
//    - A cycle-count of 1 gives a single MDWAIT cycle.
//  - Selects are combinational from instr in every state; select values outside active states are don't-care.
//  - Cycle counts: branch/jump 3 (2 for j/jal/jr/jalr); ALU 4; sw 4+waits; lw 5+waits.
//    mult=3+MULT_CYCLES; div=3+DIV_CYCLES.
//  - The PC is never written outside FETCH, DECODE(jumps) and EXEC(branches).
// CONFIGURATION
//  - `ILLEGAL_TRAP_EN defined: an unrecognised instruction in EXEC goes to TRAP. TRAP holds with all enables 0
//    and sets output port trap (1 bit, appended to PORTS only under this macro) to 1 until reset.
//  - `ILLEGAL_TRAP_EN undefined: an unrecognised instruction is a nop (EXEC -> FETCH, instr_done=1, no writes);
//    there is no trap port and no TRAP state.
// STRUCTURE
//  - Shared package mips_defs_pkg: opcode/funct constants, state encodings, and the RegDst/NPCop/MemToReg/ALUSrc/
//    Extop/ALUop encodings.
//  - Sub-module md_busy_timer (load, value, dec, zero) implements the mult/div wait counter.
// TESTING
//  - addu after reset: states 0,1,2,4,0; reg_write=1 only in WB; ALUop=000; instr_done once.
//  - lw with mem_ready low for 2 cycles: MEM held for 3 cycles; then WB with MemToReg=001, RegDst=001.
//  - beq zero=1 -> pc_we=1 in EXEC, NPCop=001; bne zero=1 -> pc_we=0; both finish in 3 cycles.
//  - mult with MULT_CYCLES=5: md_start pulses once; md_busy high for exactly 5 cycles; 8 cycles total.
//  - reset driven low in MDWAIT -> next cycle state=FETCH, md_busy=0, all enables 0.
//  - Opcode 6'b111111: with ILLEGAL_TRAP_EN, trap=1 and held; without it, nop in 3 cycles.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants, controller state encoding and datapath mux-select encodings.
// The TRAP state and its encoding only exist when ILLEGAL_TRAP_EN is defined.
package mips_defs_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] REGDST_RD = 3'b000;
   localparam logic [2:0] REGDST_RT = 3'b001;
   localparam logic [2:0] REGDST_RA = 3'b010;

   localparam logic [2:0] NPC_PC4    = 3'b000;
   localparam logic [2:0] NPC_BRANCH = 3'b001;
   localparam logic [2:0] NPC_JAL    = 3'b010;
   localparam logic [2:0] NPC_JR     = 3'b011;
   localparam logic [2:0] NPC_J      = 3'b100;

   localparam logic [2:0] M2R_ALU = 3'b000;
   localparam logic [2:0] M2R_DM  = 3'b001;
   localparam logic [2:0] M2R_PC4 = 3'b010;
   localparam logic [2:0] M2R_HI  = 3'b011;
   localparam logic [2:0] M2R_LO  = 3'b100;

   localparam logic [2:0] ALUSRC_RT  = 3'b000;
   localparam logic [2:0] ALUSRC_IMM = 3'b001;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_MDWAIT = 3'd5
`ifdef ILLEGAL_TRAP_EN
      , ST_TRAP = 3'd6
`endif
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_JALR, C_MULT, C_DIV, C_ILLEGAL
   } iclass_t;

   // mfhi/mflo ride the ALU path: they only differ in the write-back source.
   function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
      iclass_t c;
      c = C_ILLEGAL;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_MFHI, FN_MFLO: c = C_ALU;
               FN_JR:             c = C_JR;
               FN_JALR:           c = C_JALR;
               FN_MULT, FN_MULTU: c = C_MULT;
               FN_DIV, FN_DIVU:   c = C_DIV;
               default:           c = C_ILLEGAL;
            endcase
         end
         OP_ORI, OP_LUI: c = C_ALU;
         OP_LW:          c = C_LW;
         OP_SW:          c = C_SW;
         OP_BEQ:         c = C_BEQ;
         OP_BNE:         c = C_BNE;
         OP_J:           c = C_J;
         OP_JAL:         c = C_JAL;
         default:        c = C_ILLEGAL;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Down-counter that times the mult/div busy wait: load a cycle count, decrement, report zero.
module md_busy_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= value;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: decodes the IR and sequences FETCH/DECODE/EXEC/MEM/WB/MDWAIT.
// Define ILLEGAL_TRAP_EN to trap on unrecognised instructions (adds the trap port and TRAP state).
module mc_ctrl
   import mips_defs_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_we,
   output logic        ir_we,
   output logic        reg_write,
   output logic        mem_write,
   output logic [2:0]  RegDst,
   output logic [2:0]  NPCop,
   output logic [2:0]  MemToReg,
   output logic [2:0]  ALUSrc,
   output logic [1:0]  Extop,
   output logic [2:0]  ALUop,
   output logic        md_start,
   output logic        md_busy,
   output logic        instr_done,
   output logic [2:0]  state
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic        trap
`endif
);

   state_t           r_state, w_next;
   iclass_t          w_class;
   logic [5:0]       w_op, w_fn;
   logic             w_load, w_dec, w_cntZero;
   logic [CNT_W-1:0] w_loadVal;
   logic             w_pcWe, w_irWe, w_regWrite, w_memWrite, w_mdStart, w_mdBusy, w_done;
   logic             w_unused;

   assign w_op     = instr[31:26];
   assign w_fn     = instr[5:0];
   assign w_class  = decode_class(w_op, w_fn);
   assign w_unused = ^instr[25:6];

   always_comb begin
      RegDst   = REGDST_RD;
      NPCop    = NPC_PC4;
      MemToReg = M2R_ALU;
      ALUSrc   = ALUSRC_RT;
      Extop    = EXT_ZERO;
      ALUop    = ALU_ADD;
      case (w_class)
         C_ALU: begin
            if (w_op == OP_ORI) begin
               RegDst = REGDST_RT; ALUSrc = ALUSRC_IMM; Extop = EXT_ZERO; ALUop = ALU_OR;
            end else if (w_op == OP_LUI) begin
               RegDst = REGDST_RT; ALUSrc = ALUSRC_IMM; Extop = EXT_LUI;
            end else begin
               case (w_fn)
                  FN_SUBU: ALUop = ALU_SUB;
                  FN_AND:  ALUop = ALU_AND;
                  FN_OR:   ALUop = ALU_OR;
                  FN_SLT:  ALUop = ALU_SLT;
                  FN_MFHI: MemToReg = M2R_HI;
                  FN_MFLO: MemToReg = M2R_LO;
                  default: ALUop = ALU_ADD;
               endcase
            end
         end
         C_LW:         begin RegDst = REGDST_RT; MemToReg = M2R_DM; ALUSrc = ALUSRC_IMM; Extop = EXT_SIGN; end
         C_SW:         begin ALUSrc = ALUSRC_IMM; Extop = EXT_SIGN; end
         C_BEQ, C_BNE: begin NPCop = NPC_BRANCH; Extop = EXT_SIGN; ALUop = ALU_SUB; end
         C_J:          NPCop = NPC_J;
         C_JAL:        begin NPCop = NPC_JAL; RegDst = REGDST_RA; MemToReg = M2R_PC4; end
         C_JR:         NPCop = NPC_JR;
         C_JALR:       begin NPCop = NPC_JR; MemToReg = M2R_PC4; end
         default:      ;
      endcase
      // FETCH always advances the PC sequentially, whatever the stale IR says.
      if (r_state == ST_FETCH) NPCop = NPC_PC4;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= ST_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_pcWe     = 1'b0;
      w_irWe     = 1'b0;
      w_regWrite = 1'b0;
      w_memWrite = 1'b0;
      w_mdStart  = 1'b0;
      w_mdBusy   = 1'b0;
      w_done     = 1'b0;
      w_load     = 1'b0;
      w_loadVal  = '0;
      w_dec      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_irWe = 1'b1; w_pcWe = 1'b1; w_next = ST_DECODE;
         end
         ST_DECODE: begin
            case (w_class)
               C_J, C_JR:     begin w_pcWe = 1'b1; w_done = 1'b1; w_next = ST_FETCH; end
               C_JAL, C_JALR: begin w_pcWe = 1'b1; w_regWrite = 1'b1; w_done = 1'b1; w_next = ST_FETCH; end
               default:       w_next = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (w_class)
               C_ALU:      w_next = ST_WB;
               C_LW, C_SW: w_next = ST_MEM;
               C_BEQ:      begin w_pcWe = zero;  w_done = 1'b1; w_next = ST_FETCH; end
               C_BNE:      begin w_pcWe = ~zero; w_done = 1'b1; w_next = ST_FETCH; end
               C_MULT: begin
                  w_mdStart = 1'b1; w_load = 1'b1; w_loadVal = CNT_W'(MULT_CYCLES - 1); w_next = ST_MDWAIT;
               end
               C_DIV: begin
                  w_mdStart = 1'b1; w_load = 1'b1; w_loadVal = CNT_W'(DIV_CYCLES - 1); w_next = ST_MDWAIT;
               end
`ifdef ILLEGAL_TRAP_EN
               default:    w_next = ST_TRAP;
`else
               default:    begin w_done = 1'b1; w_next = ST_FETCH; end
`endif
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (w_class == C_SW) begin
                  w_memWrite = 1'b1; w_done = 1'b1; w_next = ST_FETCH;
               end else begin
                  w_next = ST_WB;
               end
            end
         end
         ST_WB: begin
            w_regWrite = 1'b1; w_done = 1'b1; w_next = ST_FETCH;
         end
         ST_MDWAIT: begin
            w_mdBusy = 1'b1;
            if (w_cntZero) begin
               w_done = 1'b1; w_next = ST_FETCH;
            end else begin
               w_dec = 1'b1;
            end
         end
`ifdef ILLEGAL_TRAP_EN
         ST_TRAP: w_next = ST_TRAP;
`endif
         default: w_next = ST_FETCH;
      endcase
   end

   md_busy_timer #(.W(CNT_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (w_load),
      .value (w_loadVal),
      .dec   (w_dec),
      .zero  (w_cntZero)
   );

`ifdef ILLEGAL_TRAP_EN
   logic r_trap;
   always_ff @(posedge clk) begin
      if (!reset)                                          r_trap <= 1'b0;
      else if ((r_state == ST_EXEC) && (w_class == C_ILLEGAL)) r_trap <= 1'b1;
   end
   assign trap = r_trap;
`endif

   // Reset masks every enable and pulse, independent of where the FSM happens to be.
   assign pc_we      = w_pcWe & reset;
   assign ir_we      = w_irWe & reset;
   assign reg_write  = w_regWrite & reset;
   assign mem_write  = w_memWrite & reset;
   assign md_start   = w_mdStart & reset;
   assign md_busy    = w_mdBusy & reset;
   assign instr_done = w_done & reset;
   assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed scenarios plus a random instruction stream compared cycle by cycle
// against a per-instruction timeline built from the controller's instruction rules.
`timescale 1ns/1ps
module tb_mc_ctrl;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;
   localparam int CNT_W       = 4;
   localparam int MAXC        = 40;

   localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4, K_J = 5, K_JAL = 6;
   localparam int K_JR = 7, K_JALR = 8, K_MULT = 9, K_DIV = 10, K_ILL = 11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = 32'h0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_we, ir_we, reg_write, mem_write, md_start, md_busy, instr_done;
   logic [2:0]  RegDst, NPCop, MemToReg, ALUSrc, ALUop, state;
   logic [1:0]  Extop;
`ifdef ILLEGAL_TRAP_EN
   logic        trap;
`endif

   int checkCount = 0;
   int failCount  = 0;

   typedef struct packed {
      logic [2:0] st;
      logic pc, ir, rw, mw, ms, mb, dn;
      logic [2:0] regDst, npc, m2r, aluSrc, aluOp;
      logic [1:0] ext;
   } cyc_t;

   cyc_t tr [MAXC];
   int   trLen;
   cyc_t expQ [$];

   mc_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .pc_we(pc_we), .ir_we(ir_we), .reg_write(reg_write), .mem_write(mem_write),
      .RegDst(RegDst), .NPCop(NPCop), .MemToReg(MemToReg), .ALUSrc(ALUSrc), .Extop(Extop),
      .ALUop(ALUop), .md_start(md_start), .md_busy(md_busy), .instr_done(instr_done),
      .state(state)
`ifdef ILLEGAL_TRAP_EN
      , .trap(trap)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] enables();
      return {pc_we, ir_we, reg_write, mem_write, md_start, md_busy, instr_done};
   endfunction

   function automatic logic [9:0] ctl(input cyc_t c);
      return {c.st, c.pc, c.ir, c.rw, c.mw, c.ms, c.mb, c.dn};
   endfunction

   function automatic int kindOf(input logic [31:0] ins);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'h00) begin
         case (fn)
            6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h10, 6'h12: return K_ALU;
            6'h08: return K_JR;
            6'h09: return K_JALR;
            6'h18, 6'h19: return K_MULT;
            6'h1a, 6'h1b: return K_DIV;
            default: return K_ILL;
         endcase
      end
      case (op)
         6'h02: return K_J;
         6'h03: return K_JAL;
         6'h04: return K_BEQ;
         6'h05: return K_BNE;
         6'h0d, 6'h0f: return K_ALU;
         6'h23: return K_LW;
         6'h2b: return K_SW;
         default: return K_ILL;
      endcase
   endfunction

   function automatic cyc_t mk(input logic [2:0] st, input logic pc, input logic rw,
                               input logic mw, input logic ms, input logic mb);
      cyc_t c;
      c = '0;
      c.st = st; c.pc = pc; c.ir = (st == 3'd0); c.rw = rw; c.mw = mw; c.ms = ms; c.mb = mb;
      return c;
   endfunction

   // Expected per-cycle timeline of one instruction, starting at its FETCH cycle.
   task automatic build_expect(input logic [31:0] ins, input logic z, input int waits);
      int k;
      k = kindOf(ins);
      expQ.delete();
      expQ.push_back(mk(3'd0, 1, 0, 0, 0, 0));
      if (k == K_J || k == K_JR || k == K_JAL || k == K_JALR) begin
         expQ.push_back(mk(3'd1, 1, (k == K_JAL || k == K_JALR), 0, 0, 0));
      end else begin
         expQ.push_back(mk(3'd1, 0, 0, 0, 0, 0));
         case (k)
            K_ALU: begin expQ.push_back(mk(3'd2, 0, 0, 0, 0, 0)); expQ.push_back(mk(3'd4, 0, 1, 0, 0, 0)); end
            K_LW, K_SW: begin
               expQ.push_back(mk(3'd2, 0, 0, 0, 0, 0));
               for (int i = 0; i < waits; i++) expQ.push_back(mk(3'd3, 0, 0, 0, 0, 0));
               if (k == K_SW) expQ.push_back(mk(3'd3, 0, 0, 1, 0, 0));
               else begin expQ.push_back(mk(3'd3, 0, 0, 0, 0, 0)); expQ.push_back(mk(3'd4, 0, 1, 0, 0, 0)); end
            end
            K_BEQ: expQ.push_back(mk(3'd2, z, 0, 0, 0, 0));
            K_BNE: expQ.push_back(mk(3'd2, !z, 0, 0, 0, 0));
            K_MULT, K_DIV: begin
               expQ.push_back(mk(3'd2, 0, 0, 0, 1, 0));
               for (int i = 0; i < ((k == K_MULT) ? MULT_CYCLES : DIV_CYCLES); i++)
                  expQ.push_back(mk(3'd5, 0, 0, 0, 0, 1));
            end
            default: expQ.push_back(mk(3'd2, 0, 0, 0, 0, 0));
         endcase
      end
      expQ[expQ.size() - 1].dn = 1'b1;
   endtask

   // Expected mux selects; the c* flags mark which EXEC selects the instruction actually defines.
   task automatic exp_sel(input logic [31:0] ins, output logic [2:0] eRd, output logic [2:0] eM2r,
                          output logic [2:0] eNpc, output logic [2:0] eSrc, output logic [2:0] eAop,
                          output logic [1:0] eExt, output bit cSrc, output bit cAop, output bit cExt);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      eRd = 3'd0; eM2r = 3'd0; eNpc = 3'd0; eSrc = 3'd0; eAop = 3'd0; eExt = 2'd0;
      cSrc = 0; cAop = 0; cExt = 0;
      if (op == 6'h00) begin
         case (fn)
            6'h21: begin cSrc = 1; cAop = 1; eAop = 3'b000; end
            6'h23: begin cSrc = 1; cAop = 1; eAop = 3'b001; end
            6'h24: begin cSrc = 1; cAop = 1; eAop = 3'b011; end
            6'h25: begin cSrc = 1; cAop = 1; eAop = 3'b010; end
            6'h2a: begin cSrc = 1; cAop = 1; eAop = 3'b100; end
            6'h10: eM2r = 3'b011;
            6'h12: eM2r = 3'b100;
            6'h08: eNpc = 3'b011;
            6'h09: begin eNpc = 3'b011; eM2r = 3'b010; end
            default: ;
         endcase
      end else begin
         case (op)
            6'h02: eNpc = 3'b100;
            6'h03: begin eNpc = 3'b010; eRd = 3'b010; eM2r = 3'b010; end
            6'h04, 6'h05: eNpc = 3'b001;
            6'h0d: begin eRd = 3'b001; eSrc = 3'b001; eExt = 2'b00; eAop = 3'b010; cSrc = 1; cAop = 1; cExt = 1; end
            6'h0f: begin eRd = 3'b001; eSrc = 3'b001; eExt = 2'b10; cSrc = 1; cExt = 1; end
            6'h23: begin eRd = 3'b001; eM2r = 3'b001; eSrc = 3'b001; eExt = 2'b01; eAop = 3'b000; cSrc = 1; cAop = 1; cExt = 1; end
            6'h2b: begin eSrc = 3'b001; eExt = 2'b01; eAop = 3'b000; cSrc = 1; cAop = 1; cExt = 1; end
            default: ;
         endcase
      end
   endtask

   // Records outputs once per cycle until instr_done (or MAXC cycles); returns just after a posedge.
   task automatic capture(input int waits);
      bit done;
      done  = 0;
      trLen = 0;
      while (!done && trLen < MAXC) begin
         mem_ready = (trLen >= 3 + waits);
         @(negedge clk);
         tr[trLen].st = state; tr[trLen].pc = pc_we; tr[trLen].ir = ir_we; tr[trLen].rw = reg_write;
         tr[trLen].mw = mem_write; tr[trLen].ms = md_start; tr[trLen].mb = md_busy; tr[trLen].dn = instr_done;
         tr[trLen].regDst = RegDst; tr[trLen].npc = NPCop; tr[trLen].m2r = MemToReg;
         tr[trLen].aluSrc = ALUSrc; tr[trLen].aluOp = ALUop; tr[trLen].ext = Extop;
         done = instr_done;
         trLen++;
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] randInstr(input bit allowIll);
      logic [11:0] tmpl [23] = '{
         12'h021, 12'h023, 12'h024, 12'h025, 12'h02a, 12'h010, 12'h012, 12'h008, 12'h009,
         12'h018, 12'h019, 12'h01a, 12'h01b, 12'h080, 12'h0c0, 12'h100, 12'h140, 12'h340,
         12'h3c0, 12'h8c0, 12'hac0, 12'hfc0, 12'h03f};
      logic [31:0] r;
      logic [11:0] t;
      r = $urandom;
      t = tmpl[$urandom_range(0, allowIll ? 22 : 20)];
      if (t[11:6] == 6'h00) return {6'h00, r[25:6], t[5:0]};
      return {t[11:6], r[25:0]};
   endfunction

   task automatic test_reset();
      instr = {6'h03, 26'h0};
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if (state !== 3'd0) begin failCount++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
      checkCount++;
      if (enables() !== 7'b0) begin failCount++; $display("[TB] FAIL reset_enables: got %b want 0000000", enables()); end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_addu();
      logic [2:0] expSt [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
      int doneCnt;
      instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
      capture(0);
      checkCount++;
      if (trLen != 4) begin failCount++; $display("[TB] FAIL addu_len: got %0d want 4", trLen); end
      doneCnt = 0;
      for (int i = 0; i < 4 && i < trLen; i++) begin
         checkCount++;
         if (tr[i].st !== expSt[i]) begin failCount++; $display("[TB] FAIL addu_state c%0d: got %0d want %0d", i, tr[i].st, expSt[i]); end
         checkCount++;
         if (tr[i].rw !== (i == 3)) begin failCount++; $display("[TB] FAIL addu_regwrite c%0d: got %b want %b", i, tr[i].rw, (i == 3)); end
         if (tr[i].dn) doneCnt++;
      end
      checkCount++;
      if (tr[2].aluOp !== 3'b000) begin failCount++; $display("[TB] FAIL addu_aluop: got %b want 000", tr[2].aluOp); end
      checkCount++;
      if (doneCnt != 1) begin failCount++; $display("[TB] FAIL addu_done_count: got %0d want 1", doneCnt); end
      checkCount++;
      if (state !== 3'd0) begin failCount++; $display("[TB] FAIL addu_return: got %0d want 0", state); end
   endtask

   task automatic test_lw_wait();
      logic [2:0] expSt [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
      instr = {6'h23, 5'd4, 5'd5, 16'h0010};
      capture(2);
      checkCount++;
      if (trLen != 7) begin failCount++; $display("[TB] FAIL lw_len: got %0d want 7", trLen); end
      for (int i = 0; i < 7 && i < trLen; i++) begin
         checkCount++;
         if (tr[i].st !== expSt[i]) begin failCount++; $display("[TB] FAIL lw_state c%0d: got %0d want %0d", i, tr[i].st, expSt[i]); end
      end
      checkCount++;
      if ({tr[6].rw, tr[6].m2r, tr[6].regDst} !== {1'b1, 3'b001, 3'b001})
         begin failCount++; $display("[TB] FAIL lw_wb: got rw=%b m2r=%b rd=%b want 1/001/001", tr[6].rw, tr[6].m2r, tr[6].regDst); end
   endtask

   task automatic test_branches();
      instr = {6'h04, 5'd1, 5'd1, 16'hfffc};
      zero  = 1'b1;
      capture(0);
      checkCount++;
      if ({trLen[3:0], tr[2].pc, tr[2].npc, tr[2].dn} !== {4'd3, 1'b1, 3'b001, 1'b1})
         begin failCount++; $display("[TB] FAIL beq_taken: got len=%0d pc=%b npc=%b dn=%b want 3/1/001/1", trLen, tr[2].pc, tr[2].npc, tr[2].dn); end
      instr = {6'h05, 5'd1, 5'd1, 16'h0004};
      zero  = 1'b1;
      capture(0);
      checkCount++;
      if ({trLen[3:0], tr[2].pc, tr[2].npc, tr[2].dn} !== {4'd3, 1'b0, 3'b001, 1'b1})
         begin failCount++; $display("[TB] FAIL bne_not_taken: got len=%0d pc=%b npc=%b dn=%b want 3/0/001/1", trLen, tr[2].pc, tr[2].npc, tr[2].dn); end
      zero = 1'b0;
   endtask

   task automatic test_mult();
      int startCnt, busyCnt;
      instr = {6'h00, 5'd2, 5'd3, 10'd0, 6'h18};
      capture(0);
      startCnt = 0;
      busyCnt  = 0;
      for (int i = 0; i < trLen; i++) begin
         if (tr[i].ms) startCnt++;
         if (tr[i].mb) busyCnt++;
      end
      checkCount++;
      if (trLen != 3 + MULT_CYCLES) begin failCount++; $display("[TB] FAIL mult_len: got %0d want %0d", trLen, 3 + MULT_CYCLES); end
      checkCount++;
      if (startCnt != 1 || tr[2].ms !== 1'b1) begin failCount++; $display("[TB] FAIL mult_start: got %0d pulses want 1 in EXEC", startCnt); end
      checkCount++;
      if (busyCnt != MULT_CYCLES) begin failCount++; $display("[TB] FAIL mult_busy: got %0d want %0d", busyCnt, MULT_CYCLES); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins;
      logic        z;
      int          w, k;
      logic [2:0]  eRd, eM2r, eNpc, eSrc, eAop;
      logic [1:0]  eExt;
      bit          cSrc, cAop, cExt;
      for (int t = 0; t < 80; t++) begin
`ifdef ILLEGAL_TRAP_EN
         ins = randInstr(1'b0);
`else
         ins = randInstr(1'b1);
`endif
         z = 1'($urandom_range(0, 1));
         w = $urandom_range(0, 3);
         k = kindOf(ins);
         build_expect(ins, z, w);
         exp_sel(ins, eRd, eM2r, eNpc, eSrc, eAop, eExt, cSrc, cAop, cExt);
         instr = ins;
         zero  = z;
         capture(w);
         checkCount++;
         if (trLen != expQ.size()) begin failCount++; $display("[TB] FAIL b2b_len i%0d %h: got %0d want %0d", t, ins, trLen, expQ.size()); end
         for (int i = 0; i < trLen && i < expQ.size(); i++) begin
            checkCount++;
            if (ctl(tr[i]) !== ctl(expQ[i]))
               begin failCount++; $display("[TB] FAIL b2b_ctl i%0d %h c%0d: got %b want %b", t, ins, i, ctl(tr[i]), ctl(expQ[i])); end
            if (expQ[i].rw) begin
               checkCount++;
               if ({tr[i].regDst, tr[i].m2r} !== {eRd, eM2r})
                  begin failCount++; $display("[TB] FAIL b2b_wbsel i%0d %h: got %b/%b want %b/%b", t, ins, tr[i].regDst, tr[i].m2r, eRd, eM2r); end
            end
            if (expQ[i].st == 3'd0 || (expQ[i].st == 3'd1 && expQ[i].pc) || (expQ[i].st == 3'd2 && (k == K_BEQ || k == K_BNE))) begin
               checkCount++;
               if (tr[i].npc !== ((expQ[i].st == 3'd0) ? 3'b000 : eNpc))
                  begin failCount++; $display("[TB] FAIL b2b_npc i%0d %h c%0d: got %b want %b", t, ins, i, tr[i].npc, (expQ[i].st == 3'd0) ? 3'b000 : eNpc); end
            end
            if (expQ[i].st == 3'd2 && (cSrc || cAop || cExt)) begin
               checkCount++;
               if ((cSrc && tr[i].aluSrc !== eSrc) || (cAop && tr[i].aluOp !== eAop) || (cExt && tr[i].ext !== eExt))
                  begin failCount++; $display("[TB] FAIL b2b_exsel i%0d %h: got %b/%b/%b want %b/%b/%b", t, ins, tr[i].aluSrc, tr[i].aluOp, tr[i].ext, eSrc, eAop, eExt); end
            end
         end
      end
   endtask

   task automatic test_reset_in_mdwait();
      instr = {6'h00, 5'd6, 5'd7, 10'd0, 6'h1a};
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkCount++;
      if ({state, md_busy} !== {3'd5, 1'b1}) begin failCount++; $display("[TB] FAIL mdwait_entry: got st=%0d busy=%b want 5/1", state, md_busy); end
      reset = 1'b0;
      #1;
      checkCount++;
      if (enables() !== 7'b0) begin failCount++; $display("[TB] FAIL mdwait_reset_mask: got %b want 0000000", enables()); end
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if ({state, enables()} !== {3'd0, 7'b0}) begin failCount++; $display("[TB] FAIL mdwait_reset: got st=%0d en=%b want 0/0000000", state, enables()); end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_illegal();
      instr = {6'h3f, 26'h155};
`ifdef ILLEGAL_TRAP_EN
      repeat (3) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkCount++;
         if ({state, trap, enables()} !== {3'd6, 1'b1, 7'b0})
            begin failCount++; $display("[TB] FAIL trap_hold c%0d: got st=%0d trap=%b en=%b want 6/1/0000000", i, state, trap, enables()); end
         @(posedge clk);
      end
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkCount++;
      if ({state, trap} !== {3'd0, 1'b0}) begin failCount++; $display("[TB] FAIL trap_clear: got st=%0d trap=%b want 0/0", state, trap); end
      @(posedge clk);
      #1 reset = 1'b1;
`else
      capture(0);
      checkCount++;
      if (trLen != 3 || tr[2].st !== 3'd2 || tr[2].dn !== 1'b1)
         begin failCount++; $display("[TB] FAIL illegal_nop: got len=%0d st=%0d dn=%b want 3/2/1", trLen, tr[2].st, tr[2].dn); end
      for (int i = 1; i < trLen; i++) begin
         checkCount++;
         if ({tr[i].pc, tr[i].rw, tr[i].mw, tr[i].ms} !== 4'b0)
            begin failCount++; $display("[TB] FAIL illegal_writes c%0d: got %b want 0000", i, {tr[i].pc, tr[i].rw, tr[i].mw, tr[i].ms}); end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_addu();
      test_lw_wait();
      test_branches();
      test_mult();
      test_back_to_back();
      test_reset_in_mdwait();
      test_addu();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
